// File: rtl/pi_cmd_master_if.sv
// Host command/response stream and processor-interface bus bundle
// for pi_cmd_master; master = the sequencer, slave = host plus target.
interface pi_cmd_master_if #(
   parameter int BLK_W  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [BLK_W-1:0]  cmd_blk_sel;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic [7:0]        cmd_len;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [BLK_W-1:0]  pi_blk_sel;
   logic [ADDR_W-1:0] pi_addr;
   logic              pi_wr_en;
   logic              pi_rd_en;
   logic [DATA_W-1:0] pi_wr_data;
   logic [DATA_W-1:0] pi_rd_data;
   logic              busy;

   modport master (
      input  cmd_valid, cmd_wr, cmd_blk_sel,
      input  cmd_addr, cmd_data, cmd_len,
      input  rsp_ready, pi_rd_data,
      output cmd_ready, rsp_valid, rsp_data,
      output pi_blk_sel, pi_addr,
      output pi_wr_en, pi_rd_en, pi_wr_data,
      output busy
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_blk_sel,
      output cmd_addr, cmd_data, cmd_len,
      output rsp_ready, pi_rd_data,
      input  cmd_ready, rsp_valid, rsp_data,
      input  pi_blk_sel, pi_addr,
      input  pi_wr_en, pi_rd_en, pi_wr_data,
      input  busy
   );
endinterface

// File: rtl/pi_cmd_master.sv
// Sequences host commands into single-cycle pi_wr_en/pi_rd_en strobes.
// Define PI_BURST_EN to enable multi-beat reads driven by cmd_len.
module pi_cmd_master #(
   parameter int BLK_W  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input logic             clk,
   input logic             rst,
   pi_cmd_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RSP
   } state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic [BLK_W-1:0]  r_blk;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wr_en;
   logic              r_rd_en;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_busy;
   logic [2:0]        r_lat_cnt;
`ifdef PI_BURST_EN
   logic [BLK_W-1:0]  r_lblk;
   logic [ADDR_W-1:0] r_laddr;
   logic [7:0]        r_left;
`else
   logic              w_unused;
   assign w_unused = &{1'b0, bus.cmd_len};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_blk       <= '0;
         r_addr      <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_lat_cnt   <= '0;
`ifdef PI_BURST_EN
         r_lblk      <= '0;
         r_laddr     <= '0;
         r_left      <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_blk       <= bus.cmd_blk_sel;
                  r_addr      <= bus.cmd_addr;
`ifdef PI_BURST_EN
                  r_lblk      <= bus.cmd_blk_sel;
                  r_laddr     <= bus.cmd_addr;
                  r_left      <= bus.cmd_wr ? 8'd0 : bus.cmd_len;
`endif
                  if (bus.cmd_wr) begin
                     r_wr_en   <= 1'b1;
                     r_wr_data <= bus.cmd_data;
                     r_state   <= S_WR;
                  end else begin
                     r_rd_en   <= 1'b1;
                     r_state   <= S_RD_ISSUE;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            S_WR: begin
               r_blk       <= '0;
               r_addr      <= '0;
               r_wr_data   <= '0;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            S_RD_ISSUE: begin
               r_lat_cnt <= 3'd1;
               r_state   <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               // Sample on the edge that closes cycle N+RD_LAT.
               if (r_lat_cnt == LAT) begin
                  r_rsp_data  <= bus.pi_rd_data;
                  r_rsp_valid <= 1'b1;
                  r_blk       <= '0;
                  r_addr      <= '0;
                  r_state     <= S_RSP;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 3'd1;
               end
            end
            S_RSP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
`ifdef PI_BURST_EN
                  if (r_left != 8'd0) begin
                     r_left  <= r_left - 8'd1;
                     r_laddr <= r_laddr + 1'b1;
                     r_addr  <= r_laddr + 1'b1;
                     r_blk   <= r_lblk;
                     r_rd_en <= 1'b1;
                     r_state <= S_RD_ISSUE;
                  end else begin
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_IDLE;
                  end
`else
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
`endif
               end
            end
            default: begin
               r_cmd_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.pi_blk_sel = r_blk;
   assign bus.pi_addr    = r_addr;
   assign bus.pi_wr_en   = r_wr_en;
   assign bus.pi_rd_en   = r_rd_en;
   assign bus.pi_wr_data = r_wr_data;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_pi_cmd_master.sv
// Directed bench for pi_cmd_master with a one-cycle-latency register
// model; define PI_BURST_EN to exercise the burst scenario.
module tb_pi_cmd_master;

   localparam int BW = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pi_cmd_master_if #(.BLK_W(BW), .ADDR_W(AW), .DATA_W(DW)) bus ();

   pi_cmd_master #(
      .BLK_W(BW), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   bit overlap = 1'b0;
   logic [7:0] rd_log[$];
   logic [31:0] rd_q = '0;

   assign bus.pi_rd_data = rd_q;

   function automatic logic [31:0] model(input logic [7:0] a);
      return (a == 8'h04) ? 32'h12345678 : {24'hA5A5A5, a};
   endfunction

   // Target model: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.pi_rd_en) begin
         rd_cnt <= rd_cnt + 1;
         rd_log.push_back(bus.pi_addr);
         rd_q <= model(bus.pi_addr);
      end
      if (bus.pi_wr_en) wr_cnt <= wr_cnt + 1;
      if (bus.pi_wr_en && bus.pi_rd_en) overlap <= 1'b1;
   end

   task automatic send_cmd(input bit wr, input logic [3:0] blk,
                           input logic [7:0] addr,
                           input logic [31:0] data,
                           input logic [7:0] len);
      bus.cmd_wr      = wr;
      bus.cmd_blk_sel = blk;
      bus.cmd_addr    = addr;
      bus.cmd_data    = data;
      bus.cmd_len     = len;
      bus.cmd_valid   = 1'b1;
      @(negedge clk);
      bus.cmd_valid   = 1'b0;
   endtask

   task automatic wait_rsp(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 ||
          bus.pi_wr_en !== 1'b0 || bus.pi_rd_en !== 1'b0 ||
          bus.rsp_valid !== 1'b0 || bus.pi_addr !== 8'h00) begin
         n_err++;
         $display("FAIL reset_hold: rdy=%b busy=%b wr=%b rd=%b rv=%b a=%h exp all 0",
                  bus.cmd_ready, bus.busy, bus.pi_wr_en,
                  bus.pi_rd_en, bus.rsp_valid, bus.pi_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: rdy=%b busy=%b exp rdy=1 busy=0",
                  bus.cmd_ready, bus.busy);
      end
   endtask

   task automatic test_write();
      int w0;
      w0 = wr_cnt;
      send_cmd(1'b1, 4'b0001, 8'h10, 32'hDEADBEEF, 8'd0);
      n_vec++;
      if (bus.pi_wr_en !== 1'b1 || bus.pi_rd_en !== 1'b0 ||
          bus.pi_blk_sel !== 4'b0001 || bus.pi_addr !== 8'h10 ||
          bus.pi_wr_data !== 32'hDEADBEEF ||
          bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL write_strobe: wr=%b rd=%b blk=%h a=%h d=%h rdy=%b busy=%b exp 1 0 1 10 deadbeef 0 1",
                  bus.pi_wr_en, bus.pi_rd_en, bus.pi_blk_sel,
                  bus.pi_addr, bus.pi_wr_data,
                  bus.cmd_ready, bus.busy);
      end
      @(negedge clk);
      n_vec++;
      if (bus.pi_wr_en !== 1'b0 || bus.cmd_ready !== 1'b1 ||
          bus.pi_addr !== 8'h00 || bus.pi_wr_data !== 32'h0 ||
          bus.busy !== 1'b0 || wr_cnt - w0 != 1) begin
         n_err++;
         $display("FAIL write_done: wr=%b rdy=%b a=%h d=%h busy=%b pulses=%0d exp 0 1 00 0 0 1",
                  bus.pi_wr_en, bus.cmd_ready, bus.pi_addr,
                  bus.pi_wr_data, bus.busy, wr_cnt - w0);
      end
   endtask

   task automatic test_read();
      int r0;
      r0 = rd_cnt;
      bus.rsp_ready = 1'b1;
      send_cmd(1'b0, 4'b0010, 8'h04, 32'h0, 8'd0);
      n_vec++;
      if (bus.pi_rd_en !== 1'b1 || bus.pi_addr !== 8'h04 ||
          bus.pi_blk_sel !== 4'b0010 || bus.pi_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL read_issue: rd=%b a=%h blk=%h wr=%b exp 1 04 2 0",
                  bus.pi_rd_en, bus.pi_addr, bus.pi_blk_sel,
                  bus.pi_wr_en);
      end
      @(negedge clk);
      n_vec++;
      if (bus.pi_rd_en !== 1'b0 || bus.pi_addr !== 8'h04 ||
          bus.pi_blk_sel !== 4'b0010 || bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL read_wait: rd=%b a=%h blk=%h rv=%b exp 0 04 2 0",
                  bus.pi_rd_en, bus.pi_addr, bus.pi_blk_sel,
                  bus.rsp_valid);
      end
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h12345678 ||
          bus.pi_addr !== 8'h00 || bus.pi_blk_sel !== 4'h0) begin
         n_err++;
         $display("FAIL read_rsp: rv=%b d=%h a=%h blk=%h exp 1 12345678 00 0",
                  bus.rsp_valid, bus.rsp_data, bus.pi_addr,
                  bus.pi_blk_sel);
      end
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.cmd_ready !== 1'b1 || rd_cnt - r0 != 1) begin
         n_err++;
         $display("FAIL read_done: rv=%b busy=%b rdy=%b pulses=%0d exp 0 0 1 1",
                  bus.rsp_valid, bus.busy, bus.cmd_ready, rd_cnt - r0);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] d;
      int r0, w0;
      bus.rsp_ready = 1'b0;
      send_cmd(1'b0, 4'b0001, 8'h22, 32'h0, 8'd0);
      wait_rsp(10, ok);
      d = bus.rsp_data;
      r0 = rd_cnt;
      w0 = wr_cnt;
      n_vec++;
      if (!ok || d !== 32'hA5A5A522) begin
         n_err++;
         $display("FAIL bp_first: seen=%b d=%h exp 1 a5a5a522", ok, d);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d ||
             bus.cmd_ready !== 1'b0 || rd_cnt != r0 ||
             wr_cnt != w0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: rv=%b d=%h rdy=%b rd+=%0d wr+=%0d exp 1 %h 0 0 0",
                     i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready,
                     rd_cnt - r0, wr_cnt - w0, d);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
          bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: rv=%b rdy=%b busy=%b exp 0 1 0",
                  bus.rsp_valid, bus.cmd_ready, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bus.rsp_ready   = 1'b1;
      bus.cmd_wr      = 1'b1;
      bus.cmd_blk_sel = 4'b0100;
      bus.cmd_addr    = 8'h30;
      bus.cmd_data    = 32'h00001111;
      bus.cmd_len     = 8'd0;
      bus.cmd_valid   = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.pi_wr_en !== 1'b1 || bus.pi_addr !== 8'h30 ||
          bus.cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_write: wr=%b a=%h rdy=%b exp 1 30 0",
                  bus.pi_wr_en, bus.pi_addr, bus.cmd_ready);
      end
      bus.cmd_wr   = 1'b0;
      bus.cmd_addr = 8'h04;
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || bus.pi_wr_en !== 1'b0 ||
          bus.pi_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: rdy=%b wr=%b rd=%b exp 1 0 0",
                  bus.cmd_ready, bus.pi_wr_en, bus.pi_rd_en);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_vec++;
      if (bus.pi_rd_en !== 1'b1 || bus.pi_addr !== 8'h04 ||
          bus.pi_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_read_accept: rd=%b a=%h wr=%b exp 1 04 0",
                  bus.pi_rd_en, bus.pi_addr, bus.pi_wr_en);
      end
      wait_rsp(6, ok);
      n_vec++;
      if (!ok || bus.rsp_data !== 32'h12345678 || overlap) begin
         n_err++;
         $display("FAIL b2b_rsp: seen=%b d=%h overlap=%b exp 1 12345678 0",
                  ok, bus.rsp_data, overlap);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      bus.rsp_ready = 1'b1;
      send_cmd(1'b0, 4'b0001, 8'h04, 32'h0, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (bus.pi_addr !== 8'h00 || bus.pi_blk_sel !== 4'h0 ||
          bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0 ||
          bus.rsp_valid !== 1'b0 || bus.pi_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_clear: a=%h blk=%h busy=%b rdy=%b rv=%b rd=%b exp all 0",
                  bus.pi_addr, bus.pi_blk_sel, bus.busy,
                  bus.cmd_ready, bus.rsp_valid, bus.pi_rd_en);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen || bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_norsp: rv_seen=%b rdy=%b exp 0 1",
                  seen, bus.cmd_ready);
      end
      send_cmd(1'b0, 4'b0001, 8'h55, 32'h0, 8'd0);
      wait_rsp(6, ok);
      n_vec++;
      if (!ok || bus.rsp_data !== 32'hA5A5A555) begin
         n_err++;
         $display("FAIL rstmid_next: seen=%b d=%h exp 1 a5a5a555",
                  ok, bus.rsp_data);
      end
      @(negedge clk);
   endtask

`ifdef PI_BURST_EN
   task automatic test_burst();
      bit ok;
      logic [7:0] a;
      bus.rsp_ready = 1'b1;
      rd_log.delete();
      send_cmd(1'b0, 4'b0010, 8'hFE, 32'h0, 8'd2);
      for (int b = 0; b < 3; b++) begin
         a = 8'hFE + 8'(b);
         wait_rsp(6, ok);
         n_vec++;
         if (!ok || bus.rsp_data !== model(a) || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL burst_beat[%0d]: seen=%b d=%h busy=%b exp 1 %h 1",
                     b, ok, bus.rsp_data, bus.busy, model(a));
         end
      end
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0 || rd_log.size() != 3) begin
         n_err++;
         $display("FAIL burst_end: busy=%b beats=%0d exp 0 3",
                  bus.busy, rd_log.size());
      end else begin
         n_vec++;
         if (rd_log[0] !== 8'hFE || rd_log[1] !== 8'hFF ||
             rd_log[2] !== 8'h00) begin
            n_err++;
            $display("FAIL burst_addr: %h %h %h exp fe ff 00",
                     rd_log[0], rd_log[1], rd_log[2]);
         end
      end
   endtask
`else
   task automatic test_len_ignored();
      bit ok;
      int r0;
      r0 = rd_cnt;
      bus.rsp_ready = 1'b1;
      send_cmd(1'b0, 4'b0000, 8'h08, 32'h0, 8'd3);
      wait_rsp(6, ok);
      n_vec++;
      if (!ok || bus.rsp_data !== 32'hA5A5A508) begin
         n_err++;
         $display("FAIL len_rsp: seen=%b d=%h exp 1 a5a5a508",
                  ok, bus.rsp_data);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (rd_cnt - r0 != 1 || bus.busy !== 1'b0 ||
          bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL len_single: pulses=%0d busy=%b rv=%b exp 1 0 0",
                  rd_cnt - r0, bus.busy, bus.rsp_valid);
      end
   endtask
`endif

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_wr      = 1'b0;
      bus.cmd_blk_sel = '0;
      bus.cmd_addr    = '0;
      bus.cmd_data    = '0;
      bus.cmd_len     = '0;
      bus.rsp_ready   = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef PI_BURST_EN
      test_burst();
`else
      test_len_ignored();
`endif
      n_vec++;
      if (overlap) begin
         n_err++;
         $display("FAIL strobe_overlap: seen=1 exp 0");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
